// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe: pipelined signed fixed-point multiplier with valid/ready flow
// control, per-beat rounding mode and a configurable output Q-format.
// Build option: define FXP_MUL_SAT_EN to clamp out-of-range results and flag
// them on out_ovf; otherwise results wrap and out_ovf is tied low.
module fxp_mul_pipe #(
    parameter int unsigned INT1     = 6,
    parameter int unsigned FRAC1    = 8,
    parameter int unsigned INT2     = 6,
    parameter int unsigned FRAC2    = 8,
    parameter int unsigned OUT_INT  = 8,
    parameter int unsigned OUT_FRAC = 8,
    parameter int unsigned PIPE     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INT1+FRAC1-1:0]        a,
    input  logic [INT2+FRAC2-1:0]        b,
    input  logic                         rnd_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_INT+OUT_FRAC-1:0]  out_data,
    output logic                         out_ovf
);

    localparam int unsigned AW    = INT1 + FRAC1;
    localparam int unsigned BW    = INT2 + FRAC2;
    localparam int unsigned W     = AW + BW;
    localparam int unsigned S     = FRAC1 + FRAC2 - OUT_FRAC;
    localparam int unsigned OW    = OUT_INT + OUT_FRAC;
    localparam int unsigned ND    = PIPE - 2;
    localparam int unsigned RC_SH = (S > 0) ? S - 1 : 0;

    // Reject configurations the datapath cannot represent
    if (OUT_FRAC > FRAC1 + FRAC2) begin : g_bad_frac
        $error("fxp_mul_pipe: OUT_FRAC must not exceed FRAC1+FRAC2");
    end
    if (PIPE < 3) begin : g_bad_pipe
        $error("fxp_mul_pipe: PIPE must be at least 3");
    end

    logic                 en;
    logic signed [AW-1:0] a_q;
    logic signed [BW-1:0] b_q;
    logic                 m1_q;
    logic                 v1_q;
    logic signed [W-1:0]  prod_d;
    logic signed [W-1:0]  p_q [ND];
    logic                 m_q [ND];
    logic                 v_q [ND];
    logic signed [W:0]    p_ext;
    logic signed [W:0]    rc;
    logic signed [W:0]    sum;
    logic signed [W:0]    r;
    logic [OW-1:0]        data_d;
    logic                 ovf_d;
    logic [OW-1:0]        out_data_q;
    logic                 out_valid_q;
    logic                 out_ovf_q;

    // Single stall domain: everything advances unless a result is waiting
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Stage 1: capture operands and mode on acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            m1_q <= 1'b0;
            v1_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q  <= a;
                b_q  <= b;
                m1_q <= rnd_mode;
            end
        end
    end

    // Exact product; binary points add so only sign extension is needed
    assign prod_d = W'(a_q) * W'(b_q);

    // Stage 2 and the optional delay stages carrying P, mode and valid
    for (genvar i = 0; i < ND; i++) begin : g_stage
        if (i == 0) begin : g_mul
            // Stage 2: register the full product
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p_q[0] <= '0;
                    m_q[0] <= 1'b0;
                    v_q[0] <= 1'b0;
                end else if (en) begin
                    p_q[0] <= prod_d;
                    m_q[0] <= m1_q;
                    v_q[0] <= v1_q;
                end
            end
        end else begin : g_dly
            // Plain delay register for the product and its side bits
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    p_q[i] <= '0;
                    m_q[i] <= 1'b0;
                    v_q[i] <= 1'b0;
                end else if (en) begin
                    p_q[i] <= p_q[i-1];
                    m_q[i] <= m_q[i-1];
                    v_q[i] <= v_q[i-1];
                end
            end
        end
    end

    // Round and rescale in W+1 bits so the rounding add cannot overflow
    always_comb begin
        p_ext = (W+1)'(p_q[ND-1]);
        rc    = '0;
        if ((S > 0) && m_q[ND-1]) begin
            rc = (W+1)'(1) << RC_SH;
        end
        sum = p_ext + rc;
        r   = sum >>> S;
    end

`ifdef FXP_MUL_SAT_EN
    localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};
    logic rng_ovf;

    // R fits in OW bits exactly when all bits from the output sign bit up agree
    if (OW <= W) begin : g_rng
        logic [W-OW+1:0] hi;
        assign hi      = r[W:OW-1];
        assign rng_ovf = !((&hi) || !(|hi));
    end else begin : g_rng_none
        assign rng_ovf = 1'b0;
    end

    // Clamp toward the sign of R on overflow
    always_comb begin
        data_d = OW'(r);
        ovf_d  = rng_ovf;
        if (rng_ovf) begin
            data_d = r[W] ? MIN_V : MAX_V;
        end
    end
`else
    // Wrap: keep the low OW bits of R
    always_comb begin
        data_d = OW'(r);
        ovf_d  = 1'b0;
    end
`endif

    // Final stage: output registers, held while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= v_q[ND-1];
            if (v_q[ND-1]) begin
                out_data_q <= data_d;
                out_ovf_q  <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// tb_fxp_mul_pipe: directed-vector bench for fxp_mul_pipe at default formats,
// PIPE=3 (main instance) and PIPE=5 (latency instance).
module tb_fxp_mul_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [13:0] a;
    logic [13:0] b;
    logic        rnd_mode;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ovf;

    logic        in_ready5;
    logic        out_valid5;
    logic [15:0] out_data5;
    logic        out_ovf5;

    int n_cmp = 0;
    int n_err = 0;

    fxp_mul_pipe #(.PIPE(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    fxp_mul_pipe #(.PIPE(5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready5),
        .a         (a),
        .b         (b),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid5),
        .out_ready (out_ready),
        .out_data  (out_data5),
        .out_ovf   (out_ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one cycle, then wait until the PIPE=3 result is visible
    task automatic run_beat(input logic [13:0] av, input logic [13:0] bv, input logic m);
        a        = av;
        b        = bv;
        rnd_mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    logic [13:0] bp_a   [6] = '{14'h0100, 14'h0200, 14'h0300, 14'h0400, 14'h0500, 14'h0600};
    logic [15:0] bp_exp [6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};

    initial begin
        int          idx;
        int          oidx;
        int          stray;
        logic [15:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        held      = '0;

        #12;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_ovf", out_ovf, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("rst_in_ready", in_ready, 1);

        // Exact product 1.5 * -2.25 = -3.375, latency 3 and 5
        a        = 14'h0180;
        b        = 14'h3DC0;   // -576
        rnd_mode = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("exact_lat_early", out_valid, 0);
        tick();
        check_eq("exact_valid", out_valid, 1);
        check_eq("exact_data", out_data, 16'hFCA0);
        check_eq("exact_ovf", out_ovf, 0);
        tick();
        check_eq("p5_lat_early", out_valid5, 0);
        tick();
        check_eq("p5_valid", out_valid5, 1);
        check_eq("p5_data", out_data5, 16'hFCA0);

        // Rounding of a half-LSB product, both signs
        run_beat(14'h0001, 14'h0080, 1'b0);
        check_eq("rnd_trunc_pos_valid", out_valid, 1);
        check_eq("rnd_trunc_pos", out_data, 16'h0000);
        run_beat(14'h0001, 14'h0080, 1'b1);
        check_eq("rnd_half_pos", out_data, 16'h0001);
        run_beat(14'h3FFF, 14'h0080, 1'b0);
        check_eq("rnd_trunc_neg", out_data, 16'hFFFF);
        run_beat(14'h3FFF, 14'h0080, 1'b1);
        check_eq("rnd_half_neg", out_data, 16'h0000);

        // Range boundaries
`ifdef FXP_MUL_SAT_EN
        run_beat(14'h1FFF, 14'h1FFF, 1'b0);
        check_eq("ovf_pos_data", out_data, 16'h7FFF);
        check_eq("ovf_pos_flag", out_ovf, 1);
        run_beat(14'h2000, 14'h1FFF, 1'b0);
        check_eq("ovf_neg_data", out_data, 16'h8000);
        check_eq("ovf_neg_flag", out_ovf, 1);
        run_beat(14'h1000, 14'h0800, 1'b0);
        check_eq("ovf_edge_pos_data", out_data, 16'h7FFF);
        check_eq("ovf_edge_pos_flag", out_ovf, 1);
`else
        run_beat(14'h1FFF, 14'h1FFF, 1'b0);
        check_eq("wrap_pos_data", out_data, 16'hFFC0);
        check_eq("wrap_pos_flag", out_ovf, 0);
        run_beat(14'h2000, 14'h1FFF, 1'b0);
        check_eq("wrap_neg_data", out_data, 16'h0020);
        check_eq("wrap_neg_flag", out_ovf, 0);
        run_beat(14'h1000, 14'h0800, 1'b0);
        check_eq("wrap_edge_pos_data", out_data, 16'h8000);
        check_eq("wrap_edge_pos_flag", out_ovf, 0);
`endif
        run_beat(14'h3000, 14'h0800, 1'b0);
        check_eq("min_exact_data", out_data, 16'h8000);
        check_eq("min_exact_flag", out_ovf, 0);
        tick();

        // Back-pressure: six beats with a 5-cycle consumer stall mid-stream
        idx  = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (idx < 6) begin
                in_valid = 1'b1;
                a        = bp_a[idx];
                b        = 14'h0100;
                rnd_mode = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && out_valid) begin
                check_eq("bp_in_ready", in_ready, 0);
                if (cyc == 4) held = out_data;
                else          check_eq("bp_hold", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (oidx < 6) check_eq($sformatf("bp_out%0d", oidx), out_data, bp_exp[oidx]);
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_count_in", idx, 6);
        check_eq("bp_count_out", oidx, 6);

        // Reset with two beats in flight
        a        = 14'h0100;
        b        = 14'h0100;
        in_valid = 1'b1;
        tick();
        a = 14'h0200;
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("rmf_pre_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rmf_valid_drop", out_valid, 0);
        check_eq("rmf_data_clear", out_data, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stray++;
        end
        check_eq("rmf_no_stale", stray, 0);
        check_eq("rmf_in_ready", in_ready, 1);
        run_beat(14'h0300, 14'h0100, 1'b0);
        check_eq("rmf_first_valid", out_valid, 1);
        check_eq("rmf_first_data", out_data, 16'h0300);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fxp_mul_pipe.md
# fxp_mul_pipe

Parametrised, pipelined signed fixed-point multiplier with valid/ready handshaking, selectable rounding, and a configurable output Q-format. It is the successor to the team's fixed Q6.8 × Q6.8 multiplier and serves as the shared multiply primitive in the datapath (filters, scalers, MAC front ends). Operands may use independent Q-formats. The block produces a result already narrowed to the consumer's format, so downstream logic needs no separate rescale stage.

## Interface
- INT1, default 6: integer bits of `a`, including the sign bit.
- FRAC1, default 8: fraction bits of `a`.
- INT2, default 6: integer bits of `b`, including the sign bit.
- FRAC2, default 8: fraction bits of `b`.
- OUT_INT, default 8: integer bits of `out_data`, including the sign bit.
- OUT_FRAC, default 8: fraction bits of `out_data`. Must satisfy OUT_FRAC ≤ FRAC1+FRAC2; elaboration fails otherwise.
- PIPE, default 3: latency in cycles. Must satisfy PIPE ≥ 3.
- clk, input, 1: clock; rising edge is active.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: block accepts a beat this cycle.
- a, input, INT1+FRAC1: signed operand A.
- b, input, INT2+FRAC2: signed operand B.
- rnd_mode, input, 1: 0 = truncate toward −∞; 1 = round half up. Travels with the beat.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, OUT_INT+OUT_FRAC: signed result.
- out_ovf, output, 1: result exceeded the output range. Travels with `out_data`.

## Operation
- Width constants:
  - W = INT1+FRAC1+INT2+FRAC2 (full product width).
  - S = FRAC1+FRAC2−OUT_FRAC (right-shift amount).
  - OW = OUT_INT+OUT_FRAC (output width).
- Stage 1 registers `a`, `b` and `rnd_mode` on acceptance, i.e. when `in_valid && in_ready`.
- Stage 2 forms the exact signed product P (W bits). Operands are sign-extended; no format alignment is needed because binary points add.
- Stages 3..PIPE−1 are plain delay registers for P, the valid bit and the mode bit. There are PIPE−3 of them, possibly none.
- Final stage:
  - Rounding constant rc = 2^(S−1) when rnd_mode=1 and S>0; otherwise 0.
  - R = (P + rc) >>> S, computed in W+1 bits so the rounding add cannot overflow.
  - Overflow when R > 2^(OW−1)−1 or R < −2^(OW−1).
  - Handling of an overflowed result depends on the configuration macro (see Configuration).
  - When S=0, R = P and no rounding is applied.
- Flow control:
  - The pipeline is a single stall domain with enable `en = !out_valid || out_ready`.
  - Every stage register, including its valid bit, advances only when `en`=1.
  - `in_ready = en`, driven combinationally.
  - Bubbles occupy stages; they are not collapsed.
- Every accepted beat produces exactly one result, in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset (asynchronous, immediate):
  - All valid bits clear to 0, so `out_valid`=0.
  - `out_data`=0 and `out_ovf`=0.
  - `in_ready`=1 while `reset` is deasserted and no result is stalled.
- Latency: a beat accepted at edge k appears with `out_valid`=1 after edge k+PIPE−1, i.e. PIPE cycles from `in_valid` being presented to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready`=1.
- While `out_valid && !out_ready`:
  - `out_data` and `out_ovf` hold stable.
  - `in_ready`=0.
  - All in-flight beats hold.
- `in_valid` with `in_ready`=0 is ignored. The source must hold the beat until it is accepted.
- Asserting `reset` mid-operation discards every in-flight beat. The first result after reset comes from the first beat accepted after reset.
- Simultaneous `out_ready`=1 with a new input beat: the output is consumed and the new beat is accepted in the same cycle.

## Configuration
- Macro `FXP_MUL_SAT_EN`.
- Defined:
  - An overflowed result clamps to 2^(OW−1)−1 (positive overflow) or −2^(OW−1) (negative overflow).
  - `out_ovf`=1 for that beat.
- Undefined:
  - `out_data` is the low OW bits of R (wrap).
  - `out_ovf` is tied to 0.
  - The comparison logic is not built.

## Test plan
All scenarios use default parameters and PIPE=3 unless stated.
- Exact product: `a`=0x0180 (1.5), `b`=−576 (−2.25), rnd_mode=0 -> `out_data`=0xFCA0 (−3.375), `out_ovf`=0, `out_valid` exactly 3 cycles after `in_valid`.
- Rounding: `a`=0x0001 (2^−8), `b`=0x0080 (0.5). rnd_mode=0 -> `out_data`=0x0000. rnd_mode=1 -> `out_data`=0x0001.
- Overflow: `a`=`b`=0x1FFF, rnd_mode=0.
  - With `FXP_MUL_SAT_EN` -> `out_data`=0x7FFF, `out_ovf`=1.
  - Without it -> `out_data`=0xFFC0, `out_ovf`=0.
  - With `FXP_MUL_SAT_EN`, `a`=−8192, `b`=0x1FFF -> `out_data`=0x8000, `out_ovf`=1.
- Back-pressure: stream 6 beats back to back, holding `out_ready`=0 for 5 cycles mid-stream -> `in_ready`=0 throughout the stall, `out_data` stable, all 6 results in order with none lost or duplicated.
- Reset mid-flight: assert `reset` asynchronously with 2 beats in flight -> `out_valid` drops within the same cycle; no stale result appears after release.
- PIPE=5: same beat as the exact-product scenario -> identical `out_data`, with latency 5 cycles.
